program_memory_ctrl: RTL and testbench

PROGRAM_MEMORY_CTRL -- requirements
Module: program_memory_ctrl

---
 rtl/program_memory_ctrl_if.sv | 33 +++
 rtl/program_memory_ctrl.sv | 144 ++++++++++++++
 tb/tb_program_memory_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/program_memory_ctrl_if.sv
// Bus bundle for program_memory_ctrl.
//   load side : load_start, load_last, ld_valid, ld_data -> ld_ready, load_done
//   fetch side: fetch_req, fetch_addr -> instruction, fetch_valid, addr_err
//   status    : halt_seen, mode
// master drives requests and load bytes; slave is the memory controller.
interface program_memory_ctrl_if #(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 8
);
    logic                 load_start;
    logic [ADD_WIDTH-1:0] load_last;
    logic                 ld_valid;
    logic [7:0]           ld_data;
    logic                 ld_ready;
    logic                 load_done;
    logic                 fetch_req;
    logic [ADD_WIDTH-1:0] fetch_addr;
    logic [WIDTH-1:0]     instruction;
    logic                 fetch_valid;
    logic                 addr_err;
    logic                 halt_seen;
    logic [1:0]           mode;

    modport master (
        output load_start, load_last, ld_valid, ld_data, fetch_req, fetch_addr,
        input  ld_ready, load_done, instruction, fetch_valid, addr_err, halt_seen, mode
    );

    modport slave (
        input  load_start, load_last, ld_valid, ld_data, fetch_req, fetch_addr,
        output ld_ready, load_done, instruction, fetch_valid, addr_err, halt_seen, mode
    );
endinterface

// File: rtl/program_memory_ctrl.sv
// Program memory controller: byte-stream loader plus 1-cycle-latency fetch port.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset (memory contents are kept)
//   bus    : program_memory_ctrl_if.slave
//            - LOAD: bytes assembled little-endian into WIDTH-bit words, written
//              to mem[0..load_last]; load_done pulses one cycle after last write
//            - RUN : fetch_req -> instruction/fetch_valid next cycle; addresses
//              >= DEPTH return NOP with addr_err
//            - mode: 0 IDLE, 1 LOAD, 2 RUN; halt_seen is sticky on opcode 7'h7F
module program_memory_ctrl #(
    parameter int               DEPTH     = 256,
    parameter int               WIDTH     = 32,
    parameter int               ADD_WIDTH = 8,
    parameter logic [WIDTH-1:0] NOP       = WIDTH'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    program_memory_ctrl_if.slave bus
);
    localparam int                   BPW       = WIDTH / 8;
    localparam int                   BCW       = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0]       LAST_BYTE = BCW'(BPW - 1);
    localparam logic [ADD_WIDTH:0]   DEPTH_X   = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [ADD_WIDTH-1:0] MAX_ADDR  = ADD_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     word_buf;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     rdata;
    logic [WIDTH-1:0]     instr_q;
    logic [BCW-1:0]       byte_cnt;
    logic [ADD_WIDTH-1:0] waddr;
    logic [ADD_WIDTH-1:0] last_q;
    logic [ADD_WIDTH-1:0] last_clip;
    logic                 load_done_q;
    logic                 fetch_valid_q;
    logic                 addr_err_q;
    logic                 halt_q;
    logic                 byte_acc;
    logic                 word_wr;
    logic                 addr_oob;

    // A byte arriving with load_start belongs to no load and is dropped.
    always_comb begin
        byte_acc = (state == LOAD) && bus.ld_valid && !bus.load_start;
        word_wr  = byte_acc && (byte_cnt == LAST_BYTE);

        // Current word with the incoming byte merged in, so the final byte
        // lands in memory on the same edge that accepts it.
        wdata = word_buf;
        for (int b = 0; b < BPW; b++) begin
            if (byte_cnt == BCW'(b))
                wdata[b*8 +: 8] = bus.ld_data;
        end

        addr_oob  = {1'b0, bus.fetch_addr} >= DEPTH_X;
        rdata     = addr_oob ? NOP : mem[bus.fetch_addr];
        last_clip = ({1'b0, bus.load_last} >= DEPTH_X) ? MAX_ADDR : bus.load_last;
    end

    // Storage has no reset so a reset never wipes a loaded program.
    always_ff @(posedge clk) begin
        if (rst_n && word_wr)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            waddr         <= '0;
            last_q        <= '0;
            word_buf      <= '0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            halt_q        <= 1'b0;
            instr_q       <= NOP;
        end else begin
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;

            if (bus.load_start) begin
                // Restart from word 0 in any state; a pending fetch is squashed.
                state    <= LOAD;
                byte_cnt <= '0;
                waddr    <= '0;
                last_q   <= last_clip;
                halt_q   <= 1'b0;
                instr_q  <= NOP;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.fetch_req)
                            instr_q <= NOP;
                    end
                    LOAD: begin
                        if (bus.fetch_req)
                            instr_q <= NOP;
                        if (byte_acc) begin
                            word_buf <= wdata;
                            if (word_wr) begin
                                byte_cnt <= '0;
                                waddr    <= waddr + 1'b1;
                                if (waddr == last_q) begin
                                    state       <= RUN;
                                    load_done_q <= 1'b1;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.fetch_req) begin
                            fetch_valid_q <= 1'b1;
                            addr_err_q    <= addr_oob;
                            instr_q       <= rdata;
                            if (rdata[6:0] == 7'h7F)
                                halt_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ld_ready    = (state == LOAD);
    assign bus.load_done   = load_done_q;
    assign bus.instruction = instr_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.halt_seen   = halt_q;
    assign bus.mode        = state;
endmodule

// File: tb/tb_program_memory_ctrl.sv
// Directed bench for program_memory_ctrl (DEPTH=200): table-driven fetch
// vectors plus hand-written load / reset / restart sequences.
module tb_program_memory_ctrl;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    program_memory_ctrl_if #(.WIDTH(32), .ADD_WIDTH(8)) bus ();

    program_memory_ctrl #(
        .DEPTH(200), .WIDTH(32), .ADD_WIDTH(8), .NOP(NOPW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        req;
        logic [7:0]  addr;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_instr;
    } fvec_t;

    fvec_t vt1 [9];
    fvec_t vt2 [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input fvec_t v, input string tag);
        bus.fetch_req  = v.req;
        bus.fetch_addr = v.addr;
        tick();
        bus.fetch_req  = 1'b0;
        chk({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'(v.exp_valid));
        chk({tag, " addr_err"},    32'(bus.addr_err),    32'(v.exp_err));
        chk({tag, " instruction"}, bus.instruction,      v.exp_instr);
    endtask

    task automatic start_load(input logic [7:0] last);
        bus.load_start = 1'b1;
        bus.load_last  = last;
        tick();
        bus.load_start = 1'b0;
    endtask

    // One byte; with gap, a dead cycle follows (except after the final byte)
    // carrying a fetch that must be refused while loading.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit final_byte);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        tick();
        bus.ld_valid = 1'b0;
        if (gap && !final_byte) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 8'd0;
            tick();
            bus.fetch_req = 1'b0;
            chk("load fetch_valid", 32'(bus.fetch_valid), 32'd0);
            chk("load instruction", bus.instruction, NOPW);
        end
    endtask

    initial begin
        logic [7:0] prog1 [8];
        logic [7:0] prog2 [12];
        logic [7:0] prog3 [4];

        prog1 = '{8'h13, 8'h00, 8'h80, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        prog2 = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'h7F, 8'h00, 8'h00, 8'h00};
        prog3 = '{8'h11, 8'h22, 8'h33, 8'h44};

        vt1[0] = '{1'b1, 8'd0,   1'b1, 1'b0, 32'h0080_0013};
        vt1[1] = '{1'b1, 8'd1,   1'b1, 1'b0, 32'h0020_0113};
        vt1[2] = '{1'b1, 8'd0,   1'b1, 1'b0, 32'h0080_0013};
        vt1[3] = '{1'b0, 8'd1,   1'b0, 1'b0, 32'h0080_0013};
        vt1[4] = '{1'b1, 8'd255, 1'b1, 1'b1, NOPW};
        vt1[5] = '{1'b0, 8'd0,   1'b0, 1'b0, NOPW};
        vt1[6] = '{1'b1, 8'd200, 1'b1, 1'b1, NOPW};
        vt1[7] = '{1'b1, 8'd1,   1'b1, 1'b0, 32'h0020_0113};
        vt1[8] = '{1'b0, 8'd0,   1'b0, 1'b0, 32'h0020_0113};

        vt2[0] = '{1'b1, 8'd0, 1'b1, 1'b0, 32'h0000_0093};
        vt2[1] = '{1'b1, 8'd1, 1'b1, 1'b0, 32'h1234_5678};
        vt2[2] = '{1'b1, 8'd2, 1'b1, 1'b0, 32'h0000_007F};

        bus.load_start = 1'b0;
        bus.load_last  = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst mode",        32'(bus.mode),        32'd0);
        chk("rst ld_ready",    32'(bus.ld_ready),    32'd0);
        chk("rst load_done",   32'(bus.load_done),   32'd0);
        chk("rst fetch_valid", 32'(bus.fetch_valid), 32'd0);
        chk("rst addr_err",    32'(bus.addr_err),    32'd0);
        chk("rst halt_seen",   32'(bus.halt_seen),   32'd0);
        chk("rst instruction", bus.instruction,      NOPW);
        rst_n = 1'b1;

        // Continuous load of two words; a byte alongside load_start is dropped
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hAA;
        start_load(8'd1);
        bus.ld_valid = 1'b0;
        chk("load1 mode",     32'(bus.mode),     32'd1);
        chk("load1 ld_ready", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog1[i], 1'b0, i == 7);
            if (i == 6) chk("load1 early done", 32'(bus.load_done), 32'd0);
        end
        chk("load1 load_done", 32'(bus.load_done), 32'd1);
        chk("load1 mode run",  32'(bus.mode),      32'd2);
        chk("load1 ld_ready",  32'(bus.ld_ready),  32'd0);

        // Fetch table: back-to-back, hold, out-of-range
        for (int i = 0; i < 9; i++) begin
            run_vec(vt1[i], $sformatf("vt1[%0d]", i));
            if (i == 0) chk("load_done pulse width", 32'(bus.load_done), 32'd0);
        end
        chk("halt after vt1", 32'(bus.halt_seen), 32'd0);

        // Load with ld_valid gaps and refused fetches; word 2 is a halt
        start_load(8'd2);
        for (int i = 0; i < 12; i++) send_byte(prog2[i], 1'b1, i == 11);
        chk("load2 load_done", 32'(bus.load_done), 32'd1);
        chk("load2 mode",      32'(bus.mode),      32'd2);
        for (int i = 0; i < 3; i++) run_vec(vt2[i], $sformatf("vt2[%0d]", i));
        chk("halt set", 32'(bus.halt_seen), 32'd1);
        run_vec(vt2[0], "vt2 rerun");
        chk("halt sticky", 32'(bus.halt_seen), 32'd1);
        start_load(8'd0);
        chk("halt cleared by load_start", 32'(bus.halt_seen), 32'd0);
        chk("reload mode", 32'(bus.mode), 32'd1);

        // Reset after two bytes, then a fresh load must start at byte 0
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst mode",     32'(bus.mode),     32'd0);
        chk("midrst ld_ready", 32'(bus.ld_ready), 32'd0);
        run_vec('{1'b1, 8'd0, 1'b0, 1'b0, NOPW}, "idle fetch");
        start_load(8'd0);
        for (int i = 0; i < 4; i++) send_byte(prog3[i], 1'b0, i == 3);
        chk("load3 load_done", 32'(bus.load_done), 32'd1);
        run_vec('{1'b1, 8'd0, 1'b1, 1'b0, 32'h4433_2211}, "load3 w0");
        run_vec('{1'b1, 8'd1, 1'b1, 1'b0, 32'h1234_5678}, "kept w1");

        // load_last beyond DEPTH clips to word 199
        start_load(8'd250);
        for (int w = 0; w < 200; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (w == 199 && b == 3)
                    chk("clip still loading", 32'(bus.mode), 32'd1);
                send_byte(8'(w), 1'b0, w == 199 && b == 3);
            end
        end
        chk("clip load_done", 32'(bus.load_done), 32'd1);
        chk("clip mode",      32'(bus.mode),      32'd2);
        run_vec('{1'b1, 8'd199, 1'b1, 1'b0, 32'hC7C7_C7C7}, "clip w199");
        run_vec('{1'b1, 8'd5,   1'b1, 1'b0, 32'h0505_0505}, "clip w5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
